// File: rtl/mlp_infer_sequencer_if.sv
// Request, layer-engine and result signals of the MLP inference sequencer.
// The sequencer connects through the slave modport. The host and layer engines
// connect through the master modport.
// MLP_SEQ_PERF_EN adds the perf_cycles counter output.
interface mlp_infer_sequencer_if #(
    parameter int unsigned OUT_DIM = 10,
    parameter int unsigned LOGIT_W = 32
);
    localparam int unsigned IDX_W = $clog2(OUT_DIM);

    logic                      req_valid;
    logic                      req_ready;
    logic                      fc1_start;
    logic                      fc1_done;
    logic                      fc2_start;
    logic                      fc2_done;
    logic                      logit_we;
    logic        [IDX_W-1:0]   logit_addr;
    logic signed [LOGIT_W-1:0] logit_data;
    logic                      res_valid;
    logic                      res_ready;
    logic        [IDX_W-1:0]   res_digit;
    logic signed [LOGIT_W-1:0] res_max;
    logic                      res_error;
    logic                      busy;
`ifdef MLP_SEQ_PERF_EN
    logic        [31:0]        perf_cycles;
`endif

    modport master (
        output req_valid, fc1_done, fc2_done, logit_we, logit_addr, logit_data, res_ready,
        input  req_ready, fc1_start, fc2_start, res_valid, res_digit, res_max, res_error, busy
`ifdef MLP_SEQ_PERF_EN
        , input perf_cycles
`endif
    );

    modport slave (
        input  req_valid, fc1_done, fc2_done, logit_we, logit_addr, logit_data, res_ready,
        output req_ready, fc1_start, fc2_start, res_valid, res_digit, res_max, res_error, busy
`ifdef MLP_SEQ_PERF_EN
        , output perf_cycles
`endif
    );
endinterface

// File: rtl/mlp_infer_sequencer.sv
// Sequences one MLP inference.
// On a request it pulses FC1 and then FC2, and snoops the FC2 logit writes to build a
// streaming argmax. It presents the predicted digit on a valid/ready result handshake.
// A per-layer watchdog ends a hung layer with an error result.
// Defining MLP_SEQ_PERF_EN adds the perf_cycles busy-cycle counter.
module mlp_infer_sequencer #(
    parameter int unsigned OUT_DIM        = 10,
    parameter int unsigned IDX_W          = $clog2(OUT_DIM),
    parameter int unsigned LOGIT_W        = 32,
    parameter int unsigned WD_W           = 20,
    parameter int unsigned TIMEOUT_CYCLES = 500000
) (
    input logic                  clk,
    input logic                  rst,
    mlp_infer_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        StIdle,
        StL1Start,
        StL1Wait,
        StL2Start,
        StL2Wait,
        StResult
    } state_e;

    localparam logic [WD_W-1:0] WdLast = WD_W'(TIMEOUT_CYCLES - 1);

    state_e                    state_q;
    logic        [WD_W-1:0]    wd_q;
    logic        [OUT_DIM-1:0] seen_q, seen_d;
    logic signed [LOGIT_W-1:0] max_q, max_d;
    logic        [IDX_W-1:0]   idx_q, idx_d;
    logic                      err_q, err_d;
    logic                      fc1_start_q, fc2_start_q, res_valid_q, busy_q;
    logic                      wd_expired;

    assign wd_expired = (wd_q == WdLast);

    // Argmax update from a snooped logit write. The result is also used on the
    // fc2_done cycle, so a write in that same cycle is counted.
    always_comb begin
        seen_d = seen_q;
        max_d  = max_q;
        idx_d  = idx_q;
        err_d  = err_q;
        if (state_q == StL2Wait && bus.logit_we) begin
            if (32'(bus.logit_addr) >= OUT_DIM) begin
                err_d = 1'b1;
            end else if (seen_q[bus.logit_addr]) begin
                err_d = 1'b1;
            end else begin
                seen_d[bus.logit_addr] = 1'b1;
                // Ties go to the lowest index so the result is independent of write order.
                if (seen_q == '0 || bus.logit_data > max_q ||
                    (bus.logit_data == max_q && bus.logit_addr < idx_q)) begin
                    max_d = bus.logit_data;
                    idx_d = bus.logit_addr;
                end
            end
        end
    end

    // Control FSM with registered start, valid and busy outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            wd_q        <= '0;
            seen_q      <= '0;
            max_q       <= '0;
            idx_q       <= '0;
            err_q       <= 1'b0;
            fc1_start_q <= 1'b0;
            fc2_start_q <= 1'b0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            fc1_start_q <= 1'b0;
            fc2_start_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.req_valid) begin
                        state_q     <= StL1Start;
                        fc1_start_q <= 1'b1;
                        busy_q      <= 1'b1;
                        seen_q      <= '0;
                        max_q       <= '0;
                        idx_q       <= '0;
                        err_q       <= 1'b0;
                    end
                end
                StL1Start: begin
                    state_q <= StL1Wait;
                    wd_q    <= '0;
                end
                StL1Wait: begin
                    // A done on the timeout cycle takes priority over the timeout.
                    if (bus.fc1_done) begin
                        state_q     <= StL2Start;
                        fc2_start_q <= 1'b1;
                    end else if (wd_expired) begin
                        state_q     <= StResult;
                        res_valid_q <= 1'b1;
                        err_q       <= 1'b1;
                        idx_q       <= '1;
                        max_q       <= '0;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
                StL2Start: begin
                    state_q <= StL2Wait;
                    wd_q    <= '0;
                end
                StL2Wait: begin
                    seen_q <= seen_d;
                    max_q  <= max_d;
                    idx_q  <= idx_d;
                    err_q  <= err_d;
                    if (bus.fc2_done) begin
                        state_q     <= StResult;
                        res_valid_q <= 1'b1;
                        err_q       <= err_d | ~(&seen_d);
                    end else if (wd_expired) begin
                        state_q     <= StResult;
                        res_valid_q <= 1'b1;
                        err_q       <= 1'b1;
                        idx_q       <= '1;
                        max_q       <= '0;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
                StResult: begin
                    if (bus.res_ready) begin
                        state_q     <= StIdle;
                        res_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    res_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    // Gate req_ready with rst so it is low during reset and high in the first cycle after.
    assign bus.req_ready = (state_q == StIdle) && !rst;
    assign bus.fc1_start = fc1_start_q;
    assign bus.fc2_start = fc2_start_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_digit = idx_q;
    assign bus.res_max   = max_q;
    assign bus.res_error = err_q;
    assign bus.busy      = busy_q;

`ifdef MLP_SEQ_PERF_EN
    logic [31:0] perf_q;

    // Count the busy cycles outside RESULT. The count holds until the next request is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_q <= '0;
        end else if (state_q == StIdle && bus.req_valid) begin
            perf_q <= '0;
        end else if (state_q != StIdle && state_q != StResult) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign bus.perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_mlp_infer_sequencer.sv
// Directed bench for mlp_infer_sequencer.
// A table of logit sets with hand-computed argmax results drives a DUT with a long timeout.
// A second DUT with TIMEOUT_CYCLES=16 covers the watchdog cases.
module tb_mlp_infer_sequencer;

    typedef logic [9:0][31:0] lvec_t;
    typedef struct {
        int    mode;   // 0 in order, 1 reverse with last write on done, 2 missing addr 9,
                       // 3 duplicate addr 3, 4 extra out-of-range addr
        lvec_t lg;
        int    digit;
        int    maxv;
        bit    err;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    mlp_infer_sequencer_if #(.OUT_DIM(10), .LOGIT_W(32)) bus ();
    mlp_infer_sequencer_if #(.OUT_DIM(10), .LOGIT_W(32)) wbus ();

    mlp_infer_sequencer #(
        .OUT_DIM(10), .LOGIT_W(32), .WD_W(20), .TIMEOUT_CYCLES(1000)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    mlp_infer_sequencer #(
        .OUT_DIM(10), .LOGIT_W(32), .WD_W(5), .TIMEOUT_CYCLES(16)
    ) dut_wd (
        .clk(clk), .rst(rst), .bus(wbus)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic lvec_t mk(input int a0, a1, a2, a3, a4, a5, a6, a7, a8, a9);
        mk = {32'(a9), 32'(a8), 32'(a7), 32'(a6), 32'(a5),
              32'(a4), 32'(a3), 32'(a2), 32'(a1), 32'(a0)};
    endfunction

    task automatic wr(input int addr, input logic [31:0] data);
        bus.logit_we   = 1'b1;
        bus.logit_addr = 4'(addr);
        bus.logit_data = data;
    endtask

    // Runs one inference up to RESULT and checks the result.
    // s_cyc is the fc1_start cycle. p_cyc is the fc2_done cycle.
    task automatic run_to_result(input vec_t v, output int s_cyc, output int p_cyc);
        int n = 0;
        while (!bus.req_ready && n < 20) begin
            step();
            n++;
        end
        chk("req_ready_before_req", 64'(bus.req_ready), 64'd1);
        bus.req_valid = 1'b1;
        step();
        bus.req_valid = 1'b0;
        chk("fc1_start_pulse", 64'(bus.fc1_start), 64'd1);
        s_cyc = cyc;
        repeat (39) step();
        bus.fc1_done = 1'b1;
        step();
        bus.fc1_done = 1'b0;
        chk("fc2_start_after_done", 64'(bus.fc2_start), 64'd1);
        step();
        if (v.mode == 1) begin
            for (int i = 9; i >= 0; i--) begin
                wr(i, v.lg[i]);
                if (i == 0) begin
                    bus.fc2_done = 1'b1;
                    p_cyc = cyc;
                end
                step();
            end
        end else begin
            for (int i = 0; i < ((v.mode == 2) ? 9 : 10); i++) begin
                wr(i, v.lg[i]);
                step();
            end
            if (v.mode == 3) begin
                wr(3, 32'd50);
                step();
            end
            if (v.mode == 4) begin
                wr(12, 32'd1000);
                step();
            end
            bus.logit_we = 1'b0;
            bus.fc2_done = 1'b1;
            p_cyc = cyc;
            step();
        end
        bus.logit_we = 1'b0;
        bus.fc2_done = 1'b0;
        chk("res_valid_after_done", 64'(bus.res_valid), 64'd1);
        chk("res_digit", 64'(bus.res_digit), 64'(v.digit));
        chk("res_max", 64'(bus.res_max), 64'(v.maxv));
        chk("res_error", 64'(bus.res_error), 64'(v.err));
    endtask

    task automatic handshake();
        bus.res_ready = 1'b1;
        step();
        bus.res_ready = 1'b0;
        chk("res_valid_after_hs", 64'(bus.res_valid), 64'd0);
        chk("req_ready_after_hs", 64'(bus.req_ready), 64'd1);
        chk("busy_after_hs", 64'(bus.busy), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        vec_t tbl[6];
        int   s, p, k;
        bit   saw2;

        tbl[0] = '{0, mk(3, -5, 9, 2, 9, 0, -1, 7, 1, 4), 2, 9, 1'b0};
        tbl[1] = '{1, mk(1, 2, 3, 4, 100, -6, 7, 8, 9, 100), 4, 100, 1'b0};
        tbl[2] = '{2, mk(3, -5, 9, 2, 9, 0, -1, 7, 1, 4), 2, 9, 1'b1};
        tbl[3] = '{3, mk(3, -5, 9, 2, 9, 0, -1, 7, 1, 4), 2, 9, 1'b1};
        tbl[4] = '{0, mk(-10, -3, -7, -3, -100, -50, -4, -9, -8, -20), 1, -3, 1'b0};
        tbl[5] = '{4, mk(5, 5, 5, 5, 5, 5, 5, 5, 5, 5), 0, 5, 1'b1};

        bus.req_valid = 0; bus.fc1_done = 0; bus.fc2_done = 0; bus.logit_we = 0;
        bus.logit_addr = 0; bus.logit_data = 0; bus.res_ready = 0;
        wbus.req_valid = 0; wbus.fc1_done = 0; wbus.fc2_done = 0; wbus.logit_we = 0;
        wbus.logit_addr = 0; wbus.logit_data = 0; wbus.res_ready = 0;

        // Reset values
        rst = 1'b1;
        repeat (3) step();
        chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_res_valid", 64'(bus.res_valid), 64'd0);
        chk("rst_fc1_start", 64'(bus.fc1_start), 64'd0);
        chk("rst_res_digit", 64'(bus.res_digit), 64'd0);
        chk("rst_res_max", 64'(bus.res_max), 64'd0);
        chk("rst_res_error", 64'(bus.res_error), 64'd0);
        rst = 1'b0;
        #1;
        chk("req_ready_after_rst", 64'(bus.req_ready), 64'd1);

        // Table-driven inferences
        foreach (tbl[i]) begin
            run_to_result(tbl[i], s, p);
`ifdef MLP_SEQ_PERF_EN
            chk("perf_cycles", 64'(bus.perf_cycles), 64'(p - s + 1));
`endif
            handshake();
`ifdef MLP_SEQ_PERF_EN
            step();
            step();
            chk("perf_cycles_hold", 64'(bus.perf_cycles), 64'(p - s + 1));
`endif
        end

        // Backpressure: result held stable, extra requests ignored
        run_to_result(tbl[0], s, p);
        bus.req_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp_res_valid", 64'(bus.res_valid), 64'd1);
            chk("bp_res_digit", 64'(bus.res_digit), 64'd2);
            chk("bp_fc1_start", 64'(bus.fc1_start), 64'd0);
        end
        bus.req_valid = 1'b0;
        handshake();
        step();
        chk("bp_no_queued_req", 64'(bus.fc1_start), 64'd0);

        // Reset during L2_WAIT
        bus.req_valid = 1'b1;
        step();
        bus.req_valid = 1'b0;
        step();
        bus.fc1_done = 1'b1;
        step();
        bus.fc1_done = 1'b0;
        step();
        wr(0, 32'd77);
        step();
        bus.logit_we = 1'b0;
        rst = 1'b1;
        bus.req_valid = 1'b1;
        step();
        chk("mid_rst_busy", 64'(bus.busy), 64'd0);
        chk("mid_rst_req_ready", 64'(bus.req_ready), 64'd0);
        chk("mid_rst_res_max", 64'(bus.res_max), 64'd0);
        chk("mid_rst_res_valid", 64'(bus.res_valid), 64'd0);
        step();
        chk("mid_rst_no_start", 64'(bus.fc1_start), 64'd0);
        rst = 1'b0;
        bus.req_valid = 1'b0;
        #1;
        chk("mid_rst_req_ready_after", 64'(bus.req_ready), 64'd1);
        run_to_result(tbl[0], s, p);
        handshake();

        // Watchdog: fc1_done never arrives
        wbus.req_valid = 1'b1;
        step();
        wbus.req_valid = 1'b0;
        chk("wd_fc1_start", 64'(wbus.fc1_start), 64'd1);
        k = 0;
        saw2 = 1'b0;
        while (!wbus.res_valid && k < 40) begin
            step();
            k++;
            if (wbus.fc2_start) saw2 = 1'b1;
        end
        chk("wd_cycles_to_result", 64'(k), 64'd17);
        chk("wd_no_fc2_start", 64'(saw2), 64'd0);
        chk("wd_res_error", 64'(wbus.res_error), 64'd1);
        chk("wd_res_digit", 64'(wbus.res_digit), 64'hF);
        chk("wd_res_max", 64'(wbus.res_max), 64'd0);
        wbus.res_ready = 1'b1;
        step();
        wbus.res_ready = 1'b0;
        chk("wd_hs_res_valid", 64'(wbus.res_valid), 64'd0);

        // Done on the last watchdog cycle of each layer wins with no error
        wbus.req_valid = 1'b1;
        step();
        wbus.req_valid = 1'b0;
        repeat (16) step();
        wbus.fc1_done = 1'b1;
        step();
        wbus.fc1_done = 1'b0;
        chk("wd_edge_fc2_start", 64'(wbus.fc2_start), 64'd1);
        repeat (7) step();
        for (int i = 0; i < 10; i++) begin
            wbus.logit_we   = 1'b1;
            wbus.logit_addr = 4'(i);
            wbus.logit_data = (i == 5) ? 32'sd42 : 32'(i);
            if (i == 9) wbus.fc2_done = 1'b1;
            step();
        end
        wbus.logit_we = 1'b0;
        wbus.fc2_done = 1'b0;
        chk("wd_edge_res_valid", 64'(wbus.res_valid), 64'd1);
        chk("wd_edge_res_error", 64'(wbus.res_error), 64'd0);
        chk("wd_edge_res_digit", 64'(wbus.res_digit), 64'd5);
        chk("wd_edge_res_max", 64'(wbus.res_max), 64'd42);
        wbus.res_ready = 1'b1;
        step();
        wbus.res_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
